nvdla_rbk_single_reg_ngrp: RTL and testbench

Parametrised single-register block for the RUBIK sub-unit. It generalises the two-group producer/consumer pointer pair to NUM_GROUPS register groups. New over the previous generation:
- producer advance strobe with wrap
- sticky per-group "consumed" events with mask and registered interrupt
- saturating illegal-write counter
Sits between the CSB register decoder and the RUBIK dual-group config registers; drives the producer pointer and reports consumer/status back to software.

---
 rtl/nvdla_rbk_single_reg_ngrp_pkg.sv | 23 ++
 rtl/nvdla_rbk_single_reg_ngrp_if.sv | 23 ++
 rtl/nvdla_rbk_single_reg_ngrp_event_sticky.sv | 53 +++++
 rtl/nvdla_rbk_single_reg_ngrp.sv | 121 ++++++++++++
 tb/tb_nvdla_rbk_single_reg_ngrp.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/nvdla_rbk_single_reg_ngrp_pkg.sv
// rtl/nvdla_rbk_single_reg_ngrp_pkg.sv - register offsets and field widths shared by RUBIK single-reg blocks
package nvdla_rbk_reg_pkg;

   // Register byte offsets decoded from the CSB bus
   localparam logic [11:0] RBK_S_STATUS     = 12'h000;
   localparam logic [11:0] RBK_S_POINTER    = 12'h004;
   localparam logic [11:0] RBK_S_EVENT      = 12'h008;
   localparam logic [11:0] RBK_S_EVENT_MASK = 12'h00C;
   localparam logic [11:0] RBK_S_CTRL       = 12'h010;
   localparam logic [11:0] RBK_S_ERR        = 12'h014;

   // Width of one per-group status field
   localparam int RBK_STATUS_FIELD_W = 2;

   // Width of the illegal-write counter
   localparam int RBK_ERR_W = 8;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [RBK_ERR_W-1:0] rbk_sat_inc(input logic [RBK_ERR_W-1:0] v);
      return (&v) ? v : v + RBK_ERR_W'(1);
   endfunction

endpackage

// File: rtl/nvdla_rbk_single_reg_ngrp_if.sv
// rtl/nvdla_rbk_single_reg_ngrp_if.sv - CSB register access bus between decoder and single-reg block
interface nvdla_rbk_single_reg_ngrp_if;
   logic [11:0] reg_offset;
   logic        reg_wr_en;
   logic [31:0] reg_wr_data;
   logic [31:0] reg_rd_data;

   // Decoder side: issues offsets/writes, receives read data
   modport master (
      output reg_offset,
      output reg_wr_en,
      output reg_wr_data,
      input  reg_rd_data
   );

   // Register block side
   modport slave (
      input  reg_offset,
      input  reg_wr_en,
      input  reg_wr_data,
      output reg_rd_data
   );
endinterface

// File: rtl/nvdla_rbk_single_reg_ngrp_event_sticky.sv
// rtl/nvdla_rbk_single_reg_ngrp_event_sticky.sv - N-bit sticky event register with W1C, mask and interrupt flop
module nvdla_rbk_event_sticky #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] set_vec,
   input  logic         clr_en,
   input  logic [N-1:0] clr_vec,
   input  logic         mask_wr_en,
   input  logic [N-1:0] mask_wr_data,
   output logic [N-1:0] event_bits,
   output logic [N-1:0] mask_bits,
   output logic         intr
);

   logic [N-1:0] event_q, event_d;
   logic [N-1:0] mask_q, mask_d;
   logic         intr_q, intr_d;

   // Next state: clear first, then OR in sets so a same-cycle set survives the clear
   always_comb begin
      event_d = event_q;
      mask_d  = mask_q;
      if (clr_en) begin
         event_d = event_q & ~clr_vec;
      end
      event_d = event_d | set_vec;
      if (mask_wr_en) begin
         mask_d = mask_wr_data;
      end
      // Interrupt follows the registered event/mask, one cycle behind them
      intr_d = |(event_q & mask_q);
   end

   // State registers, cleared asynchronously so the interrupt drops on reset without a clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         event_q <= '0;
         mask_q  <= '0;
         intr_q  <= 1'b0;
      end else begin
         event_q <= event_d;
         mask_q  <= mask_d;
         intr_q  <= intr_d;
      end
   end

   assign event_bits = event_q;
   assign mask_bits  = mask_q;
   assign intr       = intr_q;

endmodule

// File: rtl/nvdla_rbk_single_reg_ngrp.sv
// rtl/nvdla_rbk_single_reg_ngrp.sv - RUBIK producer/consumer pointer register block for NUM_GROUPS groups
module nvdla_rbk_single_reg_ngrp
   import nvdla_rbk_reg_pkg::*;
#(
   parameter  int NUM_GROUPS = 2,
   localparam int PTR_W      = (NUM_GROUPS > 2) ? $clog2(NUM_GROUPS) : 1
) (
   input  logic                                     nvdla_core_clk,
   input  logic                                     nvdla_core_rst,
   nvdla_rbk_single_reg_ngrp_if.slave               csb,
   output logic [PTR_W-1:0]                         producer,
   input  logic [PTR_W-1:0]                         consumer,
   input  logic [RBK_STATUS_FIELD_W*NUM_GROUPS-1:0] status,
   output logic                                     group_done_intr
);

   localparam logic [31:0]      NUM_GROUPS_U = 32'(NUM_GROUPS);
   localparam logic [PTR_W-1:0] LAST_GROUP   = PTR_W'(NUM_GROUPS - 1);

   logic [PTR_W-1:0]     producer_q, producer_d;
   logic [PTR_W-1:0]     consumer_q, consumer_d;
   logic [RBK_ERR_W-1:0] err_q, err_d;

   logic                  wr_status, wr_pointer, wr_event, wr_mask, wr_ctrl, wr_err, wr_undef;
   logic                  ptr_in_range;
   logic                  illegal_wr;
   logic [NUM_GROUPS-1:0] set_vec;
   logic [NUM_GROUPS-1:0] event_bits, mask_bits;
   logic [31:0]           rd_data;

   // Upper write-data bits have no destination in any register
   logic unused_wr_data;
   assign unused_wr_data = ^csb.reg_wr_data;

   // Write decode, illegal-write detection and producer/consumer/error next state
   always_comb begin
      wr_status  = csb.reg_wr_en && (csb.reg_offset == RBK_S_STATUS);
      wr_pointer = csb.reg_wr_en && (csb.reg_offset == RBK_S_POINTER);
      wr_event   = csb.reg_wr_en && (csb.reg_offset == RBK_S_EVENT);
      wr_mask    = csb.reg_wr_en && (csb.reg_offset == RBK_S_EVENT_MASK);
      wr_ctrl    = csb.reg_wr_en && (csb.reg_offset == RBK_S_CTRL);
      wr_err     = csb.reg_wr_en && (csb.reg_offset == RBK_S_ERR);
      wr_undef   = csb.reg_wr_en && !(wr_status || wr_pointer || wr_event ||
                                      wr_mask || wr_ctrl || wr_err);

      ptr_in_range = (32'(csb.reg_wr_data[PTR_W-1:0]) < NUM_GROUPS_U);
      illegal_wr   = wr_status || wr_undef || (wr_pointer && !ptr_in_range);

      producer_d = producer_q;
      if (wr_pointer && ptr_in_range) begin
         producer_d = csb.reg_wr_data[PTR_W-1:0];
      end else if (wr_ctrl && csb.reg_wr_data[0]) begin
         producer_d = (producer_q == LAST_GROUP) ? '0 : producer_q + PTR_W'(1);
      end

      consumer_d = consumer;

      // The group hardware just left is the one that has been consumed
      set_vec = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         if ((consumer != consumer_q) && (consumer_q == PTR_W'(g))) begin
            set_vec[g] = 1'b1;
         end
      end

      err_d = err_q;
      if (wr_err) begin
         err_d = '0;
      end else if (illegal_wr) begin
         err_d = rbk_sat_inc(err_q);
      end
   end

   // Pointer and error state registers
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         producer_q <= '0;
         consumer_q <= '0;
         err_q      <= '0;
      end else begin
         producer_q <= producer_d;
         consumer_q <= consumer_d;
         err_q      <= err_d;
      end
   end

   nvdla_rbk_event_sticky #(
      .N (NUM_GROUPS)
   ) u_event (
      .clk          (nvdla_core_clk),
      .rst          (nvdla_core_rst),
      .set_vec      (set_vec),
      .clr_en       (wr_event),
      .clr_vec      (csb.reg_wr_data[NUM_GROUPS-1:0]),
      .mask_wr_en   (wr_mask),
      .mask_wr_data (csb.reg_wr_data[NUM_GROUPS-1:0]),
      .event_bits   (event_bits),
      .mask_bits    (mask_bits),
      .intr         (group_done_intr)
   );

   // Zero-latency read mux; unlisted offsets and CTRL read as zero
   always_comb begin
      rd_data = '0;
      case (csb.reg_offset)
         RBK_S_STATUS:     rd_data = 32'(status);
         RBK_S_POINTER: begin
            rd_data[PTR_W-1:0]    = producer_q;
            rd_data[16 +: PTR_W]  = consumer_q;
         end
         RBK_S_EVENT:      rd_data = 32'(event_bits);
         RBK_S_EVENT_MASK: rd_data = 32'(mask_bits);
         RBK_S_ERR:        rd_data = 32'(err_q);
         default:          rd_data = '0;
      endcase
   end

   assign csb.reg_rd_data = rd_data;
   assign producer        = producer_q;

endmodule

// File: tb/tb_nvdla_rbk_single_reg_ngrp.sv
// tb/tb_nvdla_rbk_single_reg_ngrp.sv - randomized self-checking bench for nvdla_rbk_single_reg_ngrp
module tb_nvdla_rbk_single_reg_ngrp;

   localparam int NG = 3;
   localparam int PW = 2;
   localparam logic [31:0] FULL  = (32'd1 << NG) - 32'd1;
   localparam logic [31:0] PMASK = (32'd1 << PW) - 32'd1;

   logic          clk;
   logic          rst;
   logic [PW-1:0] producer;
   logic [PW-1:0] consumer;
   logic [2*NG-1:0] status;
   logic          intr;

   nvdla_rbk_single_reg_ngrp_if bus ();

   nvdla_rbk_single_reg_ngrp #(
      .NUM_GROUPS (NG)
   ) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rst  (rst),
      .csb             (bus.slave),
      .producer        (producer),
      .consumer        (consumer),
      .status          (status),
      .group_done_intr (intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: what software should see, kept as plain integers
   int m_prod, m_cons, m_ev, m_mask, m_err, m_intr;

   task automatic model_reset();
      m_prod = 0; m_cons = 0; m_ev = 0; m_mask = 0; m_err = 0; m_intr = 0;
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] off);
      case (off)
         12'h000: return 32'(status);
         12'h004: return 32'(m_prod) | (32'(m_cons) << 16);
         12'h008: return 32'(m_ev);
         12'h00C: return 32'(m_mask);
         12'h014: return 32'(m_err);
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: predict next state from the bus inputs, take the edge, commit
   task automatic tick();
      logic        wr;
      logic [11:0] off;
      logic [31:0] d;
      int n_prod, n_ev, n_mask, n_err, n_intr, cons_now;
      bit illegal;
      wr = bus.reg_wr_en; off = bus.reg_offset; d = bus.reg_wr_data;
      cons_now = int'(consumer);
      n_prod = m_prod; n_ev = m_ev; n_mask = m_mask; n_err = m_err; illegal = 0;
      n_intr = ((m_ev & m_mask) != 0) ? 1 : 0;
      if (wr) begin
         case (off)
            12'h000: illegal = 1;
            12'h004: if (int'(d & PMASK) < NG) n_prod = int'(d & PMASK); else illegal = 1;
            12'h008: n_ev = m_ev & ~int'(d & FULL);
            12'h00C: n_mask = int'(d & FULL);
            12'h010: if (d[0]) n_prod = (m_prod + 1) % NG;
            12'h014: ;
            default: illegal = 1;
         endcase
      end
      if (cons_now != m_cons) n_ev = n_ev | (1 << m_cons);
      if (wr && off == 12'h014) n_err = 0;
      else if (illegal) n_err = (m_err < 255) ? m_err + 1 : 255;
      @(posedge clk);
      #1;
      m_prod = n_prod; m_ev = n_ev; m_mask = n_mask; m_err = n_err;
      m_intr = n_intr; m_cons = cons_now;
      bus.reg_wr_en = 1'b0;
   endtask

   task automatic wr(input logic [11:0] off, input logic [31:0] data);
      bus.reg_offset  = off;
      bus.reg_wr_data = data;
      bus.reg_wr_en   = 1'b1;
      tick();
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] off);
      bus.reg_offset = off;
      #1;
      chk(tag, bus.reg_rd_data, model_read(off));
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_producer"}, 32'(producer), 32'(m_prod));
      chk({tag, "_intr"}, 32'(intr), 32'(m_intr));
   endtask

   task automatic chk_all_regs(input string tag);
      rd_chk({tag, "_status"}, 12'h000);
      rd_chk({tag, "_pointer"}, 12'h004);
      rd_chk({tag, "_event"}, 12'h008);
      rd_chk({tag, "_mask"}, 12'h00C);
      rd_chk({tag, "_ctrl"}, 12'h010);
      rd_chk({tag, "_err"}, 12'h014);
   endtask

   logic [11:0] offs [7];

   initial begin
      offs[0] = 12'h000; offs[1] = 12'h004; offs[2] = 12'h008; offs[3] = 12'h00C;
      offs[4] = 12'h010; offs[5] = 12'h014; offs[6] = 12'h018;

      // Reset and read every offset
      rst = 1'b1;
      consumer = '0;
      status = 6'(($urandom));
      bus.reg_offset = '0; bus.reg_wr_en = 1'b0; bus.reg_wr_data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk_all_regs("reset");
      chk_outputs("reset");
      rd_chk("reset_undef", 12'h7F0);

      // Advance strobe with wrap
      wr(12'h010, 32'h1); chk("adv1", 32'(producer), 32'd1);
      wr(12'h010, 32'h1); chk("adv2", 32'(producer), 32'd2);
      wr(12'h010, 32'h1); chk("adv3_wrap", 32'(producer), 32'd0);
      rd_chk("adv_pointer", 12'h004);
      wr(12'h010, 32'hFFFF_FFFE); chk("adv_zero", 32'(producer), 32'd0);
      rd_chk("ctrl_reads0", 12'h010);

      // Illegal writes and ERR counter
      wr(12'h004, 32'h3);
      chk("ptr_oor_producer", 32'(producer), 32'd0);
      chk("ptr_oor_err", dut.csb.reg_rd_data & 32'h0, 32'h0);
      rd_chk("ptr_oor_err_reg", 12'h014);
      wr(12'h004, 32'h2); chk("ptr_legal", 32'(producer), 32'd2);
      wr(12'h000, $urandom);
      wr(12'hFFC, $urandom);
      bus.reg_offset = 12'h014; #1;
      chk("err_eq3", bus.reg_rd_data, 32'd3);
      wr(12'h014, $urandom);
      rd_chk("err_clear", 12'h014);
      for (int i = 0; i < 300; i++) begin
         case (i % 3)
            0: wr(12'h000, $urandom);
            1: wr(12'h004, 32'h3);
            default: wr(12'h020 + 12'(4 * $urandom_range(0, 900)), $urandom);
         endcase
      end
      bus.reg_offset = 12'h014; #1;
      chk("err_sat255", bus.reg_rd_data, 32'd255);
      rd_chk("err_sat_model", 12'h014);
      wr(12'h014, 32'h0);
      rd_chk("err_clear2", 12'h014);

      // Consumed events, mask and interrupt latency
      wr(12'h00C, 32'h2);
      consumer = 2'd1; tick();
      bus.reg_offset = 12'h008; #1;
      chk("ev_after_0to1", bus.reg_rd_data, 32'h1);
      chk_outputs("ev01");
      tick(); chk("intr_masked_off", 32'(intr), 32'd0);
      consumer = 2'd0; tick();
      bus.reg_offset = 12'h008; #1;
      chk("ev_after_1to0", bus.reg_rd_data, 32'h3);
      chk("intr_lag", 32'(intr), 32'd0);
      tick(); chk("intr_on", 32'(intr), 32'd1);
      wr(12'h008, 32'h2);
      bus.reg_offset = 12'h008; #1;
      chk("ev_w1c", bus.reg_rd_data, 32'h1);
      chk("intr_still_on", 32'(intr), 32'd1);
      tick(); chk("intr_off", 32'(intr), 32'd0);

      // Set beats clear on the same bit
      consumer = 2'd1; tick();
      consumer = 2'd2;
      wr(12'h008, 32'h2);
      bus.reg_offset = 12'h008; #1;
      chk("set_wins_bit1", 32'(bus.reg_rd_data[1]), 32'd1);
      rd_chk("set_wins_model", 12'h008);

      // Randomized traffic against the reference model
      for (int i = 0; i < 200; i++) begin
         int k;
         logic [31:0] d;
         status = 6'($urandom);
         if ($urandom_range(0, 2) == 0) consumer = PW'($urandom_range(0, NG - 1));
         k = $urandom_range(0, 6);
         d = (k == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         if (k == 5 && $urandom_range(0, 3) != 0) k = 0;
         if ($urandom_range(0, 1) == 1) wr(offs[k], d);
         else tick();
         rd_chk($sformatf("rand%0d_rd", i), offs[$urandom_range(0, 6)]);
         chk_outputs($sformatf("rand%0d", i));
      end

      // Reset in the middle of operation
      wr(12'h00C, 32'h7);
      consumer = PW'((m_cons + 1) % NG); tick();
      wr(12'h004, 32'h2);
      tick();
      chk("pre_rst_intr", 32'(intr), 32'd1);
      chk("pre_rst_producer", 32'(producer), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_intr", 32'(intr), 32'd0);
      chk("async_rst_producer", 32'(producer), 32'd0);
      model_reset();
      consumer = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      tick(); tick();
      chk_all_regs("post_rst");
      chk_outputs("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
